// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator shift sequencer, the load/store
// shifter it drives, and the control unit that issues requests to it.
//   op_t    : requested operation (3-bit op code)
//   ctrl_t  : shifter command (hold / load / left / right)
//   state_t : sequencer FSM states
//   entry_state() : first state after an accepted request
package acc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSV  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        CTRL_HOLD  = 2'b00,
        CTRL_LOAD  = 2'b01,
        CTRL_LEFT  = 2'b10,
        CTRL_RIGHT = 2'b11
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BULK = 2'b01,
        ST_ITER = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // LOAD ignores amt; every shift-type op with a zero count is a no-op.
    // The shifter applies SHL/SHR fill in a single multi-bit command, but
    // rotates and ASR need fresh feedback each step, so they iterate.
    function automatic state_t entry_state(op_t op, logic [2:0] amt);
        state_t st;
        st = ST_DONE;
        case (op)
            OP_LOAD:                 st = ST_BULK;
            OP_SHL, OP_SHR:          st = (amt == 3'd0) ? ST_DONE : ST_BULK;
            OP_ROL, OP_ROR, OP_ASR:  st = (amt == 3'd0) ? ST_DONE : ST_ITER;
            default:                 st = ST_DONE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/acc_shift_seq_if.sv
// Request/command bundle between a control unit, the sequencer and the
// accumulator shifter.
//   start, op, amt, fill : request from the control unit
//   acc_msb, acc_lsb     : Reg_out[N-1] / Reg_out[0] fed back from the shifter
//   ctrl, num_shift      : shifter command and shift count
//   Ls, Rs               : bit entering LSB on left / MSB on right shift
//   busy, done           : sequencer status
// master = requester/shifter side, slave = sequencer.
interface acc_shift_seq_if;
    logic       start;
    logic [2:0] op;
    logic [2:0] amt;
    logic       fill;
    logic       acc_msb;
    logic       acc_lsb;
    logic [1:0] ctrl;
    logic [2:0] num_shift;
    logic       Ls;
    logic       Rs;
    logic       busy;
    logic       done;

    modport master (
        output start, op, amt, fill, acc_msb, acc_lsb,
        input  ctrl, num_shift, Ls, Rs, busy, done
    );

    modport slave (
        input  start, op, amt, fill, acc_msb, acc_lsb,
        output ctrl, num_shift, Ls, Rs, busy, done
    );
endinterface

// File: rtl/acc_shift_seq.sv
// Accumulator shift sequencer: turns one request (op, amt, fill) into the
// command sequence for an N-bit load/store shifter.
// Ports:
//   clk  : clock, rising edge
//   clr  : asynchronous active-low reset
//   bus  : acc_shift_seq_if.slave (request in, shifter command/status out)
//
// state | meaning
// IDLE  | waiting for start; request fields captured on accept
// BULK  | single shifter command (LOAD, or SHL/SHR by amt with fill)
// ITER  | one-bit rotate / arithmetic shift per cycle, amt cycles
// DONE  | one-cycle completion pulse, then back to IDLE
module acc_shift_seq
    import acc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           clr,
    acc_shift_seq_if.slave bus
);

    // Never ask the shifter for more bulk shifts than it has bit positions.
    localparam logic [2:0] MAX_BULK = (N > 7) ? 3'd7 : 3'(N - 1);

    state_t     state_q;
    state_t     state_d;
    op_t        op_q;
    logic [2:0] amt_q;
    logic       fill_q;
    logic [2:0] cnt_q;
    logic [2:0] bulk_amt;
    op_t        op_in;
    logic       accept;

    assign op_in    = op_t'(bus.op);
    assign accept   = (state_q == ST_IDLE) && bus.start;
    assign bulk_amt = (amt_q > MAX_BULK) ? MAX_BULK : amt_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            amt_q   <= 3'd0;
            fill_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_in;
                amt_q  <= bus.amt;
                fill_q <= bus.fill;
                cnt_q  <= (state_d == ST_ITER) ? bus.amt : 3'd0;
            end else if (state_q == ST_ITER) begin
                // Reaches 0 on the last ITER cycle; amt=7 gives 7 steps.
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = entry_state(op_in, bus.amt);
            ST_BULK: state_d = ST_DONE;
            ST_ITER: if (cnt_q <= 3'd1) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Commands come only from registered state and captured fields; the
    // iterative fill bits follow the live shifter feedback.
    always_comb begin
        bus.ctrl      = CTRL_HOLD;
        bus.num_shift = 3'd0;
        bus.Ls        = 1'b0;
        bus.Rs        = 1'b0;
        case (state_q)
            ST_BULK: begin
                case (op_q)
                    OP_LOAD: bus.ctrl = CTRL_LOAD;
                    OP_SHL: begin
                        bus.ctrl      = CTRL_LEFT;
                        bus.num_shift = bulk_amt;
                        bus.Ls        = fill_q;
                    end
                    OP_SHR: begin
                        bus.ctrl      = CTRL_RIGHT;
                        bus.num_shift = bulk_amt;
                        bus.Rs        = fill_q;
                    end
                    default: ;
                endcase
            end
            ST_ITER: begin
                case (op_q)
                    OP_ROL: begin
                        bus.ctrl      = CTRL_LEFT;
                        bus.num_shift = 3'd1;
                        bus.Ls        = bus.acc_msb;
                    end
                    OP_ROR: begin
                        bus.ctrl      = CTRL_RIGHT;
                        bus.num_shift = 3'd1;
                        bus.Rs        = bus.acc_lsb;
                    end
                    OP_ASR: begin
                        bus.ctrl      = CTRL_RIGHT;
                        bus.num_shift = 3'd1;
                        bus.Rs        = bus.acc_msb;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_acc_shift_seq.sv
// Bench for acc_shift_seq with a behavioural 8-bit shifter on the command
// port. Each issued request pushes its hand-computed expectation; a monitor
// on the falling edge pops it when done pulses.
module tb_acc_shift_seq;
    import acc_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    acc_shift_seq_if bus();

    acc_shift_seq #(.N(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    logic [7:0] sh_reg   = 8'h00;
    logic [7:0] load_val = 8'h00;
    int         cyc      = 0;

    assign bus.acc_msb = sh_reg[7];
    assign bus.acc_lsb = sh_reg[0];

    // Downstream shifter: not reset by clr, so it keeps partial results.
    always @(posedge clk) begin
        logic [7:0] t;
        t = sh_reg;
        case (bus.ctrl)
            2'b01: t = load_val;
            2'b10: for (int k = 0; k < int'(bus.num_shift); k++) t = {t[6:0], bus.Ls};
            2'b11: for (int k = 0; k < int'(bus.num_shift); k++) t = {bus.Rs, t[7:1]};
            default: ;
        endcase
        sh_reg <= t;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         start_cyc;
        int         lat;
        logic [7:0] acc;
        int         act;
        logic [1:0] ctrl;
        logic [2:0] ns;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor / scoreboard
    int         act_n    = 0;
    logic [1:0] obs_ctrl = 2'b00;
    logic [2:0] obs_ns   = 3'd0;

    always @(negedge clk) begin
        if (!clr) begin
            act_n = 0;
        end else begin
            if (bus.ctrl != 2'b00) begin
                act_n++;
                obs_ctrl = bus.ctrl;
                obs_ns   = bus.num_shift;
            end else begin
                chk("idle_outputs", int'({bus.num_shift, bus.Ls, bus.Rs}), 0);
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.name, "_latency"}, cyc - e.start_cyc + 1, e.lat);
                    chk({e.name, "_acc"}, int'(sh_reg), int'(e.acc));
                    chk({e.name, "_active_cycles"}, act_n, e.act);
                    chk({e.name, "_busy_in_done"}, int'(bus.busy), 1);
                    if (e.act > 0) begin
                        chk({e.name, "_ctrl"}, int'(obs_ctrl), int'(e.ctrl));
                        chk({e.name, "_num_shift"}, int'(obs_ns), int'(e.ns));
                    end
                end
                act_n = 0;
            end
        end
    end

    task automatic check_zero(input string name);
        chk({name, "_outputs_zero"},
            int'({bus.ctrl, bus.num_shift, bus.Ls, bus.Rs, bus.busy, bus.done}), 0);
    endtask

    // Called at a falling edge with the DUT idle.
    task automatic present(input string name, input logic [2:0] op, input logic [2:0] amt,
                           input logic fill, input int lat, input logic [7:0] acc,
                           input int act, input logic [1:0] ctrl, input logic [2:0] ns);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.amt   = amt;
        bus.fill  = fill;
        e.name = name; e.start_cyc = cyc; e.lat = lat; e.acc = acc;
        e.act = act; e.ctrl = ctrl; e.ns = ns;
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL completion_timeout: %0d operations still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic issue(input string name, input logic [2:0] op, input logic [2:0] amt,
                         input logic fill, input int lat, input logic [7:0] acc,
                         input int act, input logic [1:0] ctrl, input logic [2:0] ns);
        wait_idle();
        @(negedge clk);
        present(name, op, amt, fill, lat, acc, act, ctrl, ns);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.amt   = 3'd0;
        bus.fill  = 1'b0;

        repeat (2) @(negedge clk);
        check_zero("reset");

        // Release reset and request in the same cycle: accepted on first edge.
        load_val = 8'h81;
        clr = 1'b1;
        present("load_81", OP_LOAD, 3'd0, 1'b0, 3, 8'h81, 1, 2'b01, 3'd0);

        issue("shl3_fill1", OP_SHL, 3'd3, 1'b1, 3, 8'h0F, 1, 2'b10, 3'd3);
        issue("shr2_fill1", OP_SHR, 3'd2, 1'b1, 3, 8'hC3, 1, 2'b11, 3'd2);

        load_val = 8'h05;
        issue("load_05", OP_LOAD, 3'd0, 1'b0, 3, 8'h05, 1, 2'b01, 3'd0);
        issue("ror3", OP_ROR, 3'd3, 1'b0, 5, 8'hA0, 3, 2'b11, 3'd1);

        load_val = 8'h90;
        issue("load_90", OP_LOAD, 3'd0, 1'b0, 3, 8'h90, 1, 2'b01, 3'd0);
        issue("asr2", OP_ASR, 3'd2, 1'b0, 4, 8'hE4, 2, 2'b11, 3'd1);

        load_val = 8'h01;
        issue("load_01", OP_LOAD, 3'd0, 1'b0, 3, 8'h01, 1, 2'b01, 3'd0);
        issue("rol7", OP_ROL, 3'd7, 1'b0, 9, 8'h80, 7, 2'b10, 3'd1);

        issue("shr_amt0", OP_SHR, 3'd0, 1'b1, 2, 8'h80, 0, 2'b00, 3'd0);
        issue("op_reserved", OP_RSV, 3'd5, 1'b1, 2, 8'h80, 0, 2'b00, 3'd0);
        issue("nop", OP_NOP, 3'd3, 1'b0, 2, 8'h80, 0, 2'b00, 3'd0);
        issue("rol_amt0", OP_ROL, 3'd0, 1'b0, 2, 8'h80, 0, 2'b00, 3'd0);

        // Abort ROR amt=5 after one shift: 0x05 -> 0x82 is held, no done.
        load_val = 8'h05;
        issue("load_05b", OP_LOAD, 3'd0, 1'b0, 3, 8'h05, 1, 2'b01, 3'd0);
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ROR;
        bus.amt   = 3'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_zero("abort_immediate");
        repeat (3) @(negedge clk);
        check_zero("abort_held");
        chk("abort_partial_acc", int'(sh_reg), 8'h82);
        clr = 1'b1;
        present("post_reset_nop", OP_NOP, 3'd0, 1'b0, 2, 8'h82, 0, 2'b00, 3'd0);

        // start held high with LOAD: accepts in cycles c, c+3, c+6
        // (IDLE, BULK, DONE, IDLE...); starts during BULK/DONE are ignored.
        wait_idle();
        @(negedge clk);
        load_val  = 8'h3C;
        bus.start = 1'b1;
        bus.op    = OP_LOAD;
        bus.amt   = 3'd0;
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.name = $sformatf("b2b_load%0d", i);
            e.start_cyc = c + 3 * i;
            e.lat = 3; e.acc = 8'h3C; e.act = 1; e.ctrl = 2'b01; e.ns = 3'd0;
            q.push_back(e);
        end
        repeat (7) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
